sad_min_tracker: RTL and testbench
==================================

Name: sad_min_tracker

Overview:
- Downstream consumer of the PE array that the control unit drives through en_pe and ctr_word.
- Receives one SAD value per candidate displacement and tracks the running minimum SAD and its displacement over a full search window.
- At the end of the window it presents the winning motion vector and SAD on a valid/ready result port.
- Sits between the PE/accumulate path and the motion-vector writeback.

Parameters:
SAD_WIDTH, 16, width of unsigned SAD values
SEARCH_W, 16, candidates per search row (x dimension)
SEARCH_H, 16, candidate rows (y dimension)
RANGE, 8, offset subtracted from x/y index to form the signed motion vector
MV_WIDTH, 5, width of each signed motion-vector component (two's complement)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
block_start  in  1  one-cycle pulse: begin a new search window
sad_valid  in  1  sad_in carries the next candidate's SAD this cycle
sad_in  in  SAD_WIDTH  unsigned SAD of current candidate
result_ready  in  1  downstream accepts result this cycle
result_valid  out  1  result fields hold a completed window result
best_sad  out  SAD_WIDTH  minimum SAD of completed window
best_mv_x  out  MV_WIDTH  signed x displacement of minimum (x_idx - RANGE)
best_mv_y  out  MV_WIDTH  signed y displacement of minimum (y_idx - RANGE)
busy  out  1  high while in ACCUM
overrun  out  1  sticky: a result was overwritten before acceptance

Behaviour:
- Reset (rst_n low, async): state IDLE; x_idx, y_idx, running min/index cleared; result_valid, best_sad, best_mv_x, best_mv_y, busy, overrun all 0. Reset mid-window discards all progress.
- States: IDLE, ACCUM.
- IDLE: sad_valid ignored. block_start -> ACCUM.
- ACCUM: busy = 1 (registered; high from the cycle after block_start).
- Candidate order: x_idx increments fastest 0..SEARCH_W-1, then wraps to 0 and y_idx increments; y_idx runs 0..SEARCH_H-1.
- A sad_valid sampled in the same cycle as block_start is candidate (0,0); it initialises the running min unconditionally.
- Each later candidate replaces the running min only if sad_in < running min (strict). Ties keep the earlier candidate.
- The first candidate of a window always loads the running min; there is no sentinel compare.
- Completion: the sad_valid sample at (SEARCH_W-1, SEARCH_H-1) is the last candidate. On the next edge:
  - result registers load the final minimum, including that candidate's compare;
  - result_valid rises (latency 1 cycle after the last sample);
  - state -> IDLE and the indices clear.
- block_start while in ACCUM: abort the current window, restart indices at 0 and stay in ACCUM. A coincident sad_valid is candidate (0,0) of the new window. The result port is not touched.
- Result handshake: result_valid stays high until sampled with result_ready = 1, then clears on the next edge. Fields are stable while result_valid is high unless overwritten.
- Completion while result_valid = 1 and result_ready = 0: overwrite the fields, keep result_valid high, set overrun. overrun clears only on reset.
- Completion in the same cycle as a handshake (result_valid & result_ready): load the new result, result_valid stays 1, no overrun.
- Motion vector arithmetic: mv = idx - RANGE computed at MV_WIDTH+1 bits, truncated to MV_WIDTH. The parameters must keep the result in range; the defaults give -8..+7.
- sad_valid gaps are allowed in ACCUM; the indices advance only on sad_valid.

Test Plan:
- Ramp: block_start plus 256 sad_valid with sad_in = 1000 - (y*16+x) -> one cycle after the last sample, result_valid = 1, best_sad = 745, mv = (+7,+7); busy drops.
- Tie: all SADs = 50 except candidates (3,2) and (9,12) = 10 -> best_sad = 10, mv = (-5,-6) (the first occurrence wins).
- Abort: block_start, 100 candidates of 0, block_start again, then a full window with minimum 20 at (0,15) -> best_sad = 20, mv = (-8,+7); no result_valid pulse between the two starts.
- Backpressure: hold result_ready = 0 across two full windows -> second result visible and overrun = 1. Then assert result_ready for one cycle -> result_valid = 0 on the next cycle; overrun stays 1.
- Simultaneous: result_ready = 1 in the same cycle as the final candidate of the next window -> new result loaded, result_valid stays 1, overrun = 0.
- Reset mid-window at candidate 130 (async, between edges) -> all outputs 0 immediately. A subsequent full window yields the correct result with no carry-over.

Source files
------------

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: tracks the smallest SAD value over one search window.
// It also tracks the displacement of that value. When the window ends, it
// presents the winning SAD and motion vector on a valid/ready result port.
module sad_min_tracker #(
   parameter int SAD_WIDTH = 16,
   parameter int SEARCH_W  = 16,
   parameter int SEARCH_H  = 16,
   parameter int RANGE     = 8,
   parameter int MV_WIDTH  = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 block_start,
   input  logic                 sad_valid,
   input  logic [SAD_WIDTH-1:0] sad_in,
   input  logic                 result_ready,
   output logic                 result_valid,
   output logic [SAD_WIDTH-1:0] best_sad,
   output logic [MV_WIDTH-1:0]  best_mv_x,
   output logic [MV_WIDTH-1:0]  best_mv_y,
   output logic                 busy,
   output logic                 overrun
);

   localparam int XW = (SEARCH_W > 1) ? $clog2(SEARCH_W) : 1;
   localparam int YW = (SEARCH_H > 1) ? $clog2(SEARCH_H) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [XW-1:0]          x_q, x_d;
   logic [YW-1:0]          y_q, y_d;
   logic [SAD_WIDTH-1:0]   min_sad_q, min_sad_d;
   logic [XW-1:0]          min_x_q, min_x_d;
   logic [YW-1:0]          min_y_q, min_y_d;
   logic                   result_valid_q;
   logic [SAD_WIDTH-1:0]   best_sad_q;
   logic [MV_WIDTH-1:0]    best_mv_x_q, best_mv_y_q;
   logic                   busy_q;
   logic                   overrun_q;

   // block_start always restarts the window at (0,0). A coincident sample
   // therefore belongs to the new window, even if the block is already in ACCUM.
   logic                   accept;
   logic [XW-1:0]          cand_x;
   logic [YW-1:0]          cand_y;
   logic                   first_cand;
   logic                   last_cand;
   logic                   take;
   logic [MV_WIDTH-1:0]    mv_x, mv_y;

   assign accept     = sad_valid & (block_start | (state_q == ACCUM));
   assign cand_x     = block_start ? '0 : x_q;
   assign cand_y     = block_start ? '0 : y_q;
   assign first_cand = (cand_x == '0) && (cand_y == '0);
   assign last_cand  = accept && (cand_x == XW'(SEARCH_W - 1))
                              && (cand_y == YW'(SEARCH_H - 1));
   // The first candidate loads unconditionally. Later candidates replace the
   // minimum only on a strictly smaller SAD, so the earliest tie wins.
   assign take       = accept && (first_cand || (sad_in < min_sad_q));

   assign min_sad_d  = take ? sad_in : min_sad_q;
   assign min_x_d    = take ? cand_x : min_x_q;
   assign min_y_d    = take ? cand_y : min_y_q;

   // The displacement is formed one bit wider, then trimmed to the output width.
   assign mv_x = MV_WIDTH'((MV_WIDTH+1)'(min_x_d) - (MV_WIDTH+1)'(RANGE));
   assign mv_y = MV_WIDTH'((MV_WIDTH+1)'(min_y_d) - (MV_WIDTH+1)'(RANGE));

   // Raster index advance: x runs fastest; both indices clear when the window ends.
   always_comb begin
      x_d     = cand_x;
      y_d     = cand_y;
      state_d = state_q;
      if (block_start) begin
         state_d = ACCUM;
      end
      if (accept) begin
         if (cand_x == XW'(SEARCH_W - 1)) begin
            x_d = '0;
            y_d = cand_y + YW'(1);
         end else begin
            x_d = cand_x + XW'(1);
         end
      end
      if (last_cand) begin
         x_d     = '0;
         y_d     = '0;
         state_d = IDLE;
      end
   end

   // Sequential state: window control, running minimum and the result port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         x_q            <= '0;
         y_q            <= '0;
         min_sad_q      <= '0;
         min_x_q        <= '0;
         min_y_q        <= '0;
         result_valid_q <= 1'b0;
         best_sad_q     <= '0;
         best_mv_x_q    <= '0;
         best_mv_y_q    <= '0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         min_sad_q <= min_sad_d;
         min_x_q   <= min_x_d;
         min_y_q   <= min_y_d;
         busy_q    <= (state_d == ACCUM);
         if (last_cand) begin
            best_sad_q     <= min_sad_d;
            best_mv_x_q    <= mv_x;
            best_mv_y_q    <= mv_y;
            result_valid_q <= 1'b1;
            // The previous result is lost only when it was not accepted this cycle.
            if (result_valid_q && !result_ready) begin
               overrun_q <= 1'b1;
            end
         end else if (result_valid_q && result_ready) begin
            result_valid_q <= 1'b0;
         end
      end
   end

   assign result_valid = result_valid_q;
   assign best_sad     = best_sad_q;
   assign best_mv_x    = best_mv_x_q;
   assign best_mv_y    = best_mv_y_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Testbench for sad_min_tracker. It runs table-driven window patterns, then
// hand-written corner sequences, then random windows. Each result is checked
// against a reference minimum computed from the stored window contents.
module tb_sad_min_tracker;

   logic        clk;
   logic        rst_n;
   logic        block_start;
   logic        sad_valid;
   logic [15:0] sad_in;
   logic        result_ready;
   logic        result_valid;
   logic [15:0] best_sad;
   logic [4:0]  best_mv_x;
   logic [4:0]  best_mv_y;
   logic        busy;
   logic        overrun;

   int checks   = 0;
   int failures = 0;

   logic [15:0] win [256];

   typedef struct {
      int ptype;    // 0 = ramp 1000-idx, 1 = flat base with up to two minima
      int base;
      int mx, my, mx2, my2, mval;
      int gapmax;
      int exp_sad, exp_mvx, exp_mvy;
   } vec_t;

   vec_t tab [7];

   sad_min_tracker dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .block_start  (block_start),
      .sad_valid    (sad_valid),
      .sad_in       (sad_in),
      .result_ready (result_ready),
      .result_valid (result_valid),
      .best_sad     (best_sad),
      .best_mv_x    (best_mv_x),
      .best_mv_y    (best_mv_y),
      .busy         (busy),
      .overrun      (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int ptype, input int base, input int mx, input int my,
                       input int mx2, input int my2, input int mval);
      for (int i = 0; i < 256; i++) begin
         win[i] = (ptype == 0) ? 16'(1000 - i) : 16'(base);
      end
      if (ptype != 0) begin
         win[my*16 + mx]   = 16'(mval);
         win[my2*16 + mx2] = 16'(mval);
      end
   endtask

   // Reference: scan the window in raster order and keep the first strict minimum.
   task automatic ref_min(output int s, output int mvx, output int mvy);
      int bi;
      bi = 0;
      for (int i = 1; i < 256; i++) begin
         if (win[i] < win[bi]) bi = i;
      end
      s   = win[bi];
      mvx = (bi % 16) - 8;
      mvy = (bi / 16) - 8;
   endtask

   // Drive n candidates of win[]. Candidate 0 carries block_start. Random idle
   // gaps may be inserted. result_ready is rdy, except on the final candidate.
   task automatic feed(input int n, input int gapmax, input logic rdy, input logic last_rdy);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && gapmax > 0) begin
            int g;
            g = $urandom_range(0, gapmax);
            repeat (g) begin
               block_start  = 1'b0;
               sad_valid    = 1'b0;
               sad_in       = 16'($urandom);
               result_ready = rdy;
               step();
            end
         end
         block_start  = (i == 0);
         sad_valid    = 1'b1;
         sad_in       = win[i];
         result_ready = (i == 255) ? last_rdy : rdy;
         step();
         if (i == 0) check("busy_accum", int'(busy), 1);
      end
      block_start  = 1'b0;
      sad_valid    = 1'b0;
      result_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input int s, input int mvx, input int mvy);
      check({tag, "_valid"}, int'(result_valid), 1);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_sad"},   int'(best_sad), s);
      check({tag, "_mvx"},   int'($signed(best_mv_x)), mvx);
      check({tag, "_mvy"},   int'($signed(best_mv_y)), mvy);
      $display("window %s: sad=%0d mv=(%0d,%0d) overrun=%0d", tag, best_sad,
               $signed(best_mv_x), $signed(best_mv_y), overrun);
   endtask

   task automatic handshake();
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      check("handshake_clear", int'(result_valid), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rv"},   int'(result_valid), 0);
      check({tag, "_sad"},  int'(best_sad), 0);
      check({tag, "_mvx"},  int'(best_mv_x), 0);
      check({tag, "_mvy"},  int'(best_mv_y), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_ovr"},  int'(overrun), 0);
   endtask

   initial begin
      int es, ex, ey;
      logic rv_prev, ov_exp, r;

      tab[0] = '{0, 0,     0, 0,  0, 0,  0,     0, 745,   7,  7};
      tab[1] = '{1, 50,    3, 2,  9, 12, 10,    0, 10,   -5, -6};
      tab[2] = '{1, 500,   0, 0,  0, 0,  3,     0, 3,    -8, -8};
      tab[3] = '{1, 500,   15, 15, 15, 15, 0,   0, 0,     7,  7};
      tab[4] = '{1, 65535, 7, 8,  7, 8,  65534, 0, 65534, -1,  0};
      tab[5] = '{1, 9,     0, 0,  0, 0,  9,     0, 9,    -8, -8};
      tab[6] = '{1, 50,    3, 2,  9, 12, 10,    3, 10,   -5, -6};

      rst_n        = 1'b0;
      block_start  = 1'b0;
      sad_valid    = 1'b0;
      sad_in       = '0;
      result_ready = 1'b0;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // IDLE ignores sad_valid without block_start.
      sad_valid = 1'b1;
      sad_in    = 16'd1;
      step();
      sad_valid = 1'b0;
      check("idle_ignore_busy", int'(busy), 0);

      // Table-driven windows
      for (int t = 0; t < 7; t++) begin
         fill(tab[t].ptype, tab[t].base, tab[t].mx, tab[t].my, tab[t].mx2, tab[t].my2, tab[t].mval);
         feed(256, tab[t].gapmax, 1'b0, 1'b0);
         check_result($sformatf("tab%0d", t), tab[t].exp_sad, tab[t].exp_mvx, tab[t].exp_mvy);
         check("tab_overrun", int'(overrun), 0);
         handshake();
      end

      // Abort: 100 zero candidates, then a restart with the minimum at (0,15).
      fill(1, 0, 0, 0, 0, 0, 0);
      feed(100, 0, 1'b0, 1'b0);
      check("abort_no_rv", int'(result_valid), 0);
      check("abort_busy", int'(busy), 1);
      fill(1, 100, 0, 15, 0, 15, 20);
      feed(256, 0, 1'b0, 1'b0);
      check_result("abort", 20, -8, 7);
      handshake();

      // Backpressure across two windows
      fill(0, 0, 0, 0, 0, 0, 0);
      feed(256, 0, 1'b0, 1'b0);
      check_result("bp1", 745, 7, 7);
      check("bp1_overrun", int'(overrun), 0);
      fill(1, 50, 3, 2, 9, 12, 10);
      feed(256, 0, 1'b0, 1'b0);
      check_result("bp2", 10, -5, -6);
      check("bp2_overrun", int'(overrun), 1);
      handshake();
      check("bp_overrun_sticky", int'(overrun), 1);
      step();
      check("bp_rv_stays_low", int'(result_valid), 0);

      // Asynchronous reset clears overrun.
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset2");
      #4 rst_n = 1'b1;
      step();

      // Simultaneous: a handshake in the same cycle as completion.
      fill(0, 0, 0, 0, 0, 0, 0);
      feed(256, 0, 1'b0, 1'b0);
      check_result("sim1", 745, 7, 7);
      fill(1, 500, 0, 0, 0, 0, 3);
      feed(256, 0, 1'b0, 1'b1);
      check_result("sim2", 3, -8, -8);
      check("sim_overrun", int'(overrun), 0);
      step();
      check("sim_rv_held", int'(result_valid), 1);

      // Reset mid-window at candidate 130, between clock edges.
      fill(1, 0, 0, 0, 0, 0, 0);
      feed(130, 0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      #10 rst_n = 1'b1;
      step();
      fill(1, 200, 15, 15, 15, 15, 33);
      feed(256, 0, 1'b0, 1'b0);
      check_result("postreset", 33, 7, 7);
      check("postreset_overrun", int'(overrun), 0);

      // Random windows checked against the reference minimum and overrun bookkeeping.
      rv_prev = 1'b1;
      ov_exp  = 1'b0;
      for (int w = 0; w < 8; w++) begin
         for (int i = 0; i < 256; i++) begin
            win[i] = (w % 2 == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
         end
         r = 1'($urandom_range(0, 1));
         feed(256, 2, r, r);
         ref_min(es, ex, ey);
         if (rv_prev && !r) ov_exp = 1'b1;
         check_result($sformatf("rand%0d", w), es, ex, ey);
         check("rand_overrun", int'(overrun), int'(ov_exp));
         rv_prev = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
